tick_period_meter: RTL
======================

// Module: tick_period_meter
// PURPOSE
//  Consumer end of the slow-tick interface: measures clock cycles between rising edges of a tick input.
//  Reports each period with a 1-cycle valid strobe, tracks min/max period and edge count, flags loss of tick.
//  Sits downstream of the slow clock generator to verify its rate, or measures any external slow pulse train.
// PARAMETERS
//  WIDTH           32        width of period, min/max and edge counters
//  TIMEOUT_CYCLES  4000000   cycles without an edge before timeout; must be >= 2 and < 2**WIDTH
//  SYNC_STAGES     2         input synchroniser flops on tick_in; legal values are 0 (tick already in clock domain) or 2
// PORTS
//  clock         in   1      system clock; all logic on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  tick_in       in   1      tick to measure; pulse or level, rising edge is the event
//  clear         in   1      synchronous clear of statistics and state (1-cycle pulse)
//  period_out    out  WIDTH  last measured period in clock cycles
//  period_valid  out  1      high for exactly 1 cycle when period_out updates
//  min_period    out  WIDTH  smallest period since reset/clear
//  max_period    out  WIDTH  largest period since reset/clear
//  edge_count    out  WIDTH  rising edges detected since reset/clear; wraps at 2**WIDTH
//  timeout       out  1      sticky: TIMEOUT_CYCLES passed with no edge
//  measuring     out  1      high while state == MEASURE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, period_out=0, period_valid=0, min_period=all ones, max_period=0,
//    edge_count=0, timeout=0, cycle counter=0, sync/edge flops=0.
//  Edge detect: s = tick_in after SYNC_STAGES flops; edge = s & ~s_d, where s_d is s delayed 1 cycle.
//    A level held high counts as one edge.
//  Latency: tick_in rise to period_valid high = SYNC_STAGES+1 clock edges.
//  Counter: set to 1 on each accepted edge, then +1 per cycle in MEASURE.
//    Period = cycles between consecutive edge-detect cycles (edges P cycles apart -> P).
//  FSM:
//    IDLE    : edge -> MEASURE, count<=1, edge_count+1; no period reported.
//    MEASURE : edge -> period_out<=count, period_valid<=1, min/max update, edge_count+1, count<=1.
//              no edge and count==TIMEOUT_CYCLES -> TIMEOUT, timeout<=1; count holds.
//              edge in the same cycle count==TIMEOUT_CYCLES: the edge wins and period TIMEOUT_CYCLES is reported.
//    TIMEOUT : edge -> MEASURE, count<=1, edge_count+1; no period reported (stale interval); timeout stays 1.
//  min/max: compare against the new period in the same cycle period_out loads.
//    The first period after reset/clear sets both min and max.
//  clear=1: state<=IDLE, min=all ones, max=0, edge_count=0, timeout=0, count=0, period_valid=0.
//    period_out retains its value. clear has priority over a coincident edge; that edge is ignored.
//    Sync/edge flops keep running, so an edge is never double-detected after clear.
//  period_valid is never high on two consecutive cycles (minimum period is 2 because edge needs s_d=0).
//  Reset mid-measurement: all state is lost and the next edge is treated as the first (IDLE).
// TESTING (bench: TIMEOUT_CYCLES=100, SYNC_STAGES=2, WIDTH=32)
//  1. 1-cycle pulses every 50 cycles, 4 pulses -> 3 period_valid strobes, period_out=50,
//     min=max=50, edge_count=4, timeout=0; first strobe 3 cycles after the 2nd pulse rises.
//  2. Pulse gaps 10, 30, 20 -> period_out sequence 10, 30, 20; min=10, max=30.
//  3. One pulse, then none for 150 cycles -> timeout=1 exactly 100 cycles after first edge detect,
//     measuring=0. Next pulse: no strobe, measuring=1. Following pulse 40 later: period_out=40, timeout still 1.
//  4. Edge lands exactly on count==100 -> period_valid=1, period_out=100, timeout=0.
//  5. clear asserted in the same cycle as an edge after 3 periods -> min=all ones, max=0,
//     edge_count=0, state IDLE. Next two pulses 25 apart -> period 25, edge_count=2.
//  6. tick_in held high 60 cycles, then low, then high again 80 cycles after the first rise ->
//     edge_count=2, one strobe with period 80. Additionally: assert reset_n=0 mid-count -> all outputs at
//     reset values immediately, with no clock required.

Source files
------------

// File: rtl/tick_period_meter.sv
// Measures clock cycles between rising edges of a slow tick input, keeps
// min/max/edge-count statistics and flags a sticky timeout when ticks stop.
module tick_period_meter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic [WIDTH-1:0] min_period,
    output logic [WIDTH-1:0] max_period,
    output logic [WIDTH-1:0] edge_count,
    output logic             timeout,
    output logic             measuring
);

    localparam logic [WIDTH-1:0] TO_LIMIT = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TMO     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic             to_q, to_d;
    logic             tick_s;
    logic             tick_s_q;
    logic             edge_det;

    // Synchroniser is skipped entirely when the tick is already in this domain.
    if (SYNC_STAGES == 2) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) sync_q <= 2'b00;
            else          sync_q <= {sync_q[0], tick_in};
        end
        assign tick_s = sync_q[1];
    end else begin : g_nosync
        assign tick_s = tick_in;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tick_s_q <= 1'b0;
        else          tick_s_q <= tick_s;
    end

    assign edge_det = tick_s & ~tick_s_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            min_q    <= '1;
            max_q    <= '0;
            ec_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            min_q    <= min_d;
            max_q    <= max_d;
            ec_q     <= ec_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        pv_d     = 1'b0;
        min_d    = min_q;
        max_d    = max_q;
        ec_d     = ec_q;
        to_d     = to_q;
        // clear beats a coincident edge; period_out deliberately survives it
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            min_d   = '1;
            max_d   = '0;
            ec_d    = '0;
            to_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, TMO: begin
                    if (edge_det) begin
                        state_d = MEASURE;
                        count_d = ONE;
                        ec_d    = ec_q + ONE;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        period_d = count_q;
                        pv_d     = 1'b1;
                        if (count_q < min_q) min_d = count_q;
                        if (count_q > max_q) max_d = count_q;
                        ec_d     = ec_q + ONE;
                        count_d  = ONE;
                    end else if (count_q == TO_LIMIT) begin
                        state_d = TMO;
                        to_d    = 1'b1;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period_out   = period_q;
    assign period_valid = pv_q;
    assign min_period   = min_q;
    assign max_period   = max_q;
    assign edge_count   = ec_q;
    assign timeout      = to_q;
    assign measuring    = (state_q == MEASURE);

endmodule
